step_dir_decoder: RTL and testbench
===================================

Name: step_dir_decoder

Overview:
- Receive end of the step/dir motor interface: decodes the step/dir pair produced by the motor control block into signed position, per-4ms step rate, a moving flag and segment-complete status.
- Used as the loopback/monitor beside each motor channel, and as the step input of a slave axis.
- Runs on the 10 MHz system clock with the shared 4 ms tick.
- Every step_in transition, rising or falling, is one motor step, matching the toggle-per-step generator.

Parameters:
POS_W, 16, width of the position counter.
IDLE_TICKS, 8, number of 4 ms ticks with no step edge before moving drops.
DIR_SETUP, 2, minimum number of clocks between a synced dir change and an accepted step edge.
FILT_LEN, 4, glitch filter length in clocks (used only with the optional feature).

Ports:
CLK_10MHZ  in  1  system clock
RST_N  in  1  synchronous, active-low reset
clock_4ms  in  1  single-cycle 4 ms tick
step_in  in  1  asynchronous step line; each edge is one step
dir_in  in  1  asynchronous direction; 1 = +1 per step, 0 = -1 per step
deltaPos  in  16  expected step count of the next segment
newPosSignal  in  1  single-cycle pulse; arms a segment of deltaPos steps
clr_err  in  1  clears dir_err
position  out  POS_W  signed step position
steps_per_tick  out  8  accepted edges in the last complete 4 ms window
moving  out  1  high while edges are seen within IDLE_TICKS ticks
seg_remaining  out  16  steps still expected in the current segment
seg_done  out  1  one-cycle pulse when the segment completes
dir_err  out  1  sticky direction-setup violation

Behaviour:
- Reset (RST_N low at a clock edge):
  - position=0, steps_per_tick=0, seg_remaining=0, seg_done=0, dir_err=0, moving=0.
  - idle counter preset to IDLE_TICKS; dir-setup counter saturated; synchronizers loaded with 0.
  - Reset mid-segment abandons the segment with no seg_done.
- Input path:
  - step_in and dir_in each pass a 2-FF synchronizer.
  - An accepted edge is a difference between the synced step and its registered copy.
  - position updates on the 3rd clock after step_in changes.
- Position:
  - On each accepted edge, synced dir=1 adds 1 and dir=0 subtracts 1.
  - Wraps modulo 2^POS_W with no saturation.
- Segment FSM, states IDLE, ARMED, RUN:
  - IDLE --newPosSignal--> ARMED, seg_remaining<=deltaPos. If deltaPos==0, instead pulse seg_done on the next clock and stay in IDLE.
  - ARMED --first edge--> RUN, and that edge decrements seg_remaining.
  - RUN: each edge decrements. When the decrement reaches 0, pulse seg_done in the same cycle seg_remaining becomes 0, then go to IDLE.
  - Edges in IDLE update position only. seg_remaining stays 0 and never underflows.
  - newPosSignal in ARMED or RUN reloads deltaPos and enters ARMED. No seg_done for the aborted segment.
  - newPosSignal and an edge in the same cycle: the reload wins. The edge counts in position but not against the new segment.
- Rate window:
  - Edge counter increments per edge, saturating at 255.
  - On clock_4ms: steps_per_tick<=count (plus the coincident edge, if any, saturated), then the counter clears. A coincident edge is counted in the closing window.
- Moving:
  - Idle counter clears on an edge and increments on clock_4ms, saturating at IDLE_TICKS.
  - moving = (idle counter < IDLE_TICKS), registered.
  - Edge and tick in the same cycle: the edge wins (counter clears).
- Dir check:
  - Counter clears when synced dir changes and saturates at DIR_SETUP.
  - An edge accepted while the counter < DIR_SETUP sets dir_err.
  - clr_err clears dir_err; a set in the same cycle wins.

Optional Feature:
STEP_GLITCH_FILTER_EN:
- Defined: the synced step must hold a new level for FILT_LEN consecutive clocks before the edge is accepted. Pulses shorter than FILT_LEN are ignored, and latency grows by FILT_LEN clocks.
- Undefined: the synced step is accepted directly; there is no filter logic.

Test Plan:
- Reset: hold RST_N=0 for 2 clocks -> position=0, seg_remaining=0, steps_per_tick=0, moving=0, dir_err=0.
- deltaPos=5, newPosSignal, dir_in=1, 5 toggles 20 clocks apart -> position=5, seg_remaining 5->0, exactly one seg_done pulse 3 clocks after the 5th toggle.
- Idle, dir_in=0 held, 3 toggles from position 0 -> position=0xFFFD, seg_remaining=0, no seg_done.
- clock_4ms every 1000 clocks, toggle every 100 clocks -> steps_per_tick=10 after each tick. Stop toggling -> moving falls after 8 ticks.
- dir_in change 1 clock before a toggle -> dir_err=1. Pulse clr_err -> dir_err=0.
- deltaPos=10, 4 edges, then newPosSignal with deltaPos=3 -> no seg_done at the reload; seg_done after 3 more edges; position=7. With STEP_GLITCH_FILTER_EN, a 2-clock step_in pulse leaves position unchanged.

Source files
------------

// File: rtl/step_dir_decoder.sv
// Step/dir receiver: synchronizes step/dir, tracks signed position, step rate per 4 ms window,
// moving status, segment completion and direction-setup errors. STEP_GLITCH_FILTER_EN adds a step glitch filter.
module step_dir_decoder #(
    parameter int POS_W      = 16,
    parameter int IDLE_TICKS = 8,
    parameter int DIR_SETUP  = 2
`ifdef STEP_GLITCH_FILTER_EN
    , parameter int FILT_LEN = 4
`endif
) (
    input  logic             CLK_10MHZ,
    input  logic             RST_N,
    input  logic             clock_4ms,
    input  logic             step_in,
    input  logic             dir_in,
    input  logic [15:0]      deltaPos,
    input  logic             newPosSignal,
    input  logic             clr_err,
    output logic [POS_W-1:0] position,
    output logic [7:0]       steps_per_tick,
    output logic             moving,
    output logic [15:0]      seg_remaining,
    output logic             seg_done,
    output logic             dir_err
);
    localparam int SC_W = $clog2(DIR_SETUP + 1);
    localparam int IT_W = $clog2(IDLE_TICKS + 1);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN} seg_state_e;

    logic [1:0]       step_sync_q;
    logic [1:0]       dir_sync_q;
    logic             step_prev_q;
    logic             dir_prev_q;
    logic             step_edge;
    logic             dir_change;
    logic [SC_W-1:0]  setup_q;
    logic             setup_viol;
    logic [POS_W-1:0] position_q;
    logic [7:0]       edge_cnt_q;
    logic [7:0]       edge_cnt_d;
    logic [7:0]       spt_q;
    logic [IT_W-1:0]  idle_q;
    logic [IT_W-1:0]  idle_d;
    logic             moving_q;
    seg_state_e       state_q;
    logic [15:0]      seg_rem_q;
    logic             seg_done_q;
    logic             dir_err_q;

    always_ff @(posedge CLK_10MHZ) begin
        if (!RST_N) begin
            step_sync_q <= 2'b00;
            dir_sync_q  <= 2'b00;
            dir_prev_q  <= 1'b0;
        end else begin
            step_sync_q <= {step_sync_q[0], step_in};
            dir_sync_q  <= {dir_sync_q[0], dir_in};
            dir_prev_q  <= dir_sync_q[1];
        end
    end

`ifdef STEP_GLITCH_FILTER_EN
    localparam int FC_W = $clog2(FILT_LEN + 1);
    logic [FC_W-1:0] filt_cnt_q;

    // A new level is accepted only after it has been stable for FILT_LEN further clocks.
    assign step_edge = (step_sync_q[1] != step_prev_q) && (filt_cnt_q == FC_W'(FILT_LEN));

    always_ff @(posedge CLK_10MHZ) begin
        if (!RST_N) begin
            step_prev_q <= 1'b0;
            filt_cnt_q  <= '0;
        end else if (step_sync_q[1] == step_prev_q) begin
            filt_cnt_q  <= '0;
        end else if (filt_cnt_q == FC_W'(FILT_LEN)) begin
            step_prev_q <= step_sync_q[1];
            filt_cnt_q  <= '0;
        end else begin
            filt_cnt_q  <= filt_cnt_q + 1'b1;
        end
    end
`else
    assign step_edge = step_sync_q[1] ^ step_prev_q;

    always_ff @(posedge CLK_10MHZ) begin
        if (!RST_N) begin
            step_prev_q <= 1'b0;
        end else begin
            step_prev_q <= step_sync_q[1];
        end
    end
`endif

    assign dir_change = dir_sync_q[1] ^ dir_prev_q;
    // An edge coincident with the dir change itself has zero setup time.
    assign setup_viol = step_edge && (dir_change || (setup_q < SC_W'(DIR_SETUP)));

    always_ff @(posedge CLK_10MHZ) begin
        if (!RST_N) begin
            setup_q   <= SC_W'(DIR_SETUP);
            dir_err_q <= 1'b0;
        end else begin
            if (dir_change) begin
                setup_q <= '0;
            end else if (setup_q < SC_W'(DIR_SETUP)) begin
                setup_q <= setup_q + 1'b1;
            end
            if (setup_viol) begin
                dir_err_q <= 1'b1;
            end else if (clr_err) begin
                dir_err_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK_10MHZ) begin
        if (!RST_N) begin
            position_q <= '0;
        end else if (step_edge) begin
            position_q <= dir_sync_q[1] ? position_q + POS_W'(1) : position_q - POS_W'(1);
        end
    end

    always_comb begin
        edge_cnt_d = edge_cnt_q;
        if (step_edge && edge_cnt_q != 8'hFF) begin
            edge_cnt_d = edge_cnt_q + 8'd1;
        end
    end

    always_comb begin
        idle_d = idle_q;
        if (step_edge) begin
            idle_d = '0;
        end else if (clock_4ms && idle_q < IT_W'(IDLE_TICKS)) begin
            idle_d = idle_q + 1'b1;
        end
    end

    always_ff @(posedge CLK_10MHZ) begin
        if (!RST_N) begin
            edge_cnt_q <= 8'd0;
            spt_q      <= 8'd0;
            idle_q     <= IT_W'(IDLE_TICKS);
            moving_q   <= 1'b0;
        end else begin
            if (clock_4ms) begin
                spt_q      <= edge_cnt_d;
                edge_cnt_q <= 8'd0;
            end else begin
                edge_cnt_q <= edge_cnt_d;
            end
            idle_q   <= idle_d;
            moving_q <= (idle_d < IT_W'(IDLE_TICKS));
        end
    end

    // A reload always wins over a coincident edge; a zero-length segment completes at once.
    always_ff @(posedge CLK_10MHZ) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            seg_rem_q  <= 16'd0;
            seg_done_q <= 1'b0;
        end else begin
            seg_done_q <= 1'b0;
            if (newPosSignal) begin
                if (deltaPos == 16'd0) begin
                    state_q    <= S_IDLE;
                    seg_rem_q  <= 16'd0;
                    seg_done_q <= 1'b1;
                end else begin
                    state_q    <= S_ARMED;
                    seg_rem_q  <= deltaPos;
                end
            end else if (step_edge && state_q != S_IDLE) begin
                seg_rem_q <= seg_rem_q - 16'd1;
                if (seg_rem_q == 16'd1) begin
                    state_q    <= S_IDLE;
                    seg_done_q <= 1'b1;
                end else begin
                    state_q    <= S_RUN;
                end
            end
        end
    end

    assign position       = position_q;
    assign steps_per_tick = spt_q;
    assign moving         = moving_q;
    assign seg_remaining  = seg_rem_q;
    assign seg_done       = seg_done_q;
    assign dir_err        = dir_err_q;
endmodule

// File: tb/tb_step_dir_decoder.sv
// Testbench for step_dir_decoder: vector table, directed corner sequences and a randomized
// run against a step-level reference model.
module tb_step_dir_decoder;
`ifdef STEP_GLITCH_FILTER_EN
    localparam int FE = 4;
`else
    localparam int FE = 0;
`endif
    localparam int LAT = 3 + FE;

    logic        clk;
    logic        RST_N;
    logic        clock_4ms;
    logic        step_in;
    logic        dir_in;
    logic [15:0] deltaPos;
    logic        newPosSignal;
    logic        clr_err;
    logic [15:0] position;
    logic [7:0]  steps_per_tick;
    logic        moving;
    logic [15:0] seg_remaining;
    logic        seg_done;
    logic        dir_err;

    step_dir_decoder dut (
        .CLK_10MHZ     (clk),
        .RST_N         (RST_N),
        .clock_4ms     (clock_4ms),
        .step_in       (step_in),
        .dir_in        (dir_in),
        .deltaPos      (deltaPos),
        .newPosSignal  (newPosSignal),
        .clr_err       (clr_err),
        .position      (position),
        .steps_per_tick(steps_per_tick),
        .moving        (moving),
        .seg_remaining (seg_remaining),
        .seg_done      (seg_done),
        .dir_err       (dir_err)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    always @(negedge clk) if (seg_done === 1'b1) done_cnt++;

    typedef struct {
        logic        arm;
        logic [15:0] dp;
        logic        dir;
        int          n;
        logic [15:0] pos;
        logic [15:0] rem;
        int          dn;
    } vec_t;

    // Reference model state: position, remaining steps, expected seg_done count.
    logic [15:0] m_pos;
    logic [15:0] m_rem;
    int          m_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        RST_N = 1'b0; step_in = 1'b0; newPosSignal = 1'b0; clr_err = 1'b0; clock_4ms = 1'b0;
        cyc(2);
        RST_N = 1'b1;
        cyc(6);
    endtask

    task automatic do_arm(input logic [15:0] dp);
        deltaPos = dp; newPosSignal = 1'b1;
        cyc(1);
        newPosSignal = 1'b0;
        cyc(1);
    endtask

    task automatic do_step();
        step_in = ~step_in;
        cyc(LAT + 1);
    endtask

    task automatic set_dir(input logic d);
        if (dir_in !== d) begin
            dir_in = d;
            cyc(6);
        end
    endtask

    task automatic tick_pulse();
        clock_4ms = 1'b1;
        cyc(1);
        clock_4ms = 1'b0;
    endtask

    task automatic m_arm(input logic [15:0] dp);
        if (dp == 16'd0) begin
            m_rem = 16'd0;
            m_done++;
        end else begin
            m_rem = dp;
        end
    endtask

    task automatic m_step(input logic d);
        m_pos = d ? m_pos + 16'd1 : m_pos - 16'd1;
        if (m_rem != 16'd0) begin
            m_rem = m_rem - 16'd1;
            if (m_rem == 16'd0) m_done++;
        end
    endtask

    vec_t vecs[7];
    int   d0;
    logic [15:0] p0;

    initial begin
        vecs[0] = '{1'b1, 16'd5,      1'b1, 5, 16'h0005, 16'd0,      1};
        vecs[1] = '{1'b0, 16'd0,      1'b0, 8, 16'hFFFD, 16'd0,      0};
        vecs[2] = '{1'b1, 16'd3,      1'b1, 2, 16'hFFFF, 16'd1,      0};
        vecs[3] = '{1'b1, 16'd0,      1'b1, 0, 16'hFFFF, 16'd0,      1};
        vecs[4] = '{1'b1, 16'd4,      1'b1, 6, 16'h0005, 16'd0,      1};
        vecs[5] = '{1'b1, 16'hFFFF,   1'b0, 3, 16'h0002, 16'hFFFC,   0};
        vecs[6] = '{1'b1, 16'd2,      1'b0, 2, 16'h0000, 16'd0,      1};

        dir_in = 1'b1; deltaPos = 16'd0;
        RST_N = 1'b0; step_in = 1'b0; newPosSignal = 1'b0; clr_err = 1'b0; clock_4ms = 1'b0;
        cyc(2);
        chk("rst_position", {16'd0, position}, 32'd0);
        chk("rst_seg_remaining", {16'd0, seg_remaining}, 32'd0);
        chk("rst_steps_per_tick", {24'd0, steps_per_tick}, 32'd0);
        chk("rst_moving", {31'd0, moving}, 32'd0);
        chk("rst_dir_err", {31'd0, dir_err}, 32'd0);
        chk("rst_seg_done", {31'd0, seg_done}, 32'd0);
        RST_N = 1'b1;
        cyc(6);

        // Table-driven segment/position vectors, cumulative from reset.
        for (int i = 0; i < 7; i++) begin
            d0 = done_cnt;
            set_dir(vecs[i].dir);
            if (vecs[i].arm) do_arm(vecs[i].dp);
            for (int k = 0; k < vecs[i].n; k++) do_step();
            cyc(1);
            $display("vec %0d pos=%h rem=%h done=%0d", i, position, seg_remaining, done_cnt - d0);
            chk("vec_position", {16'd0, position}, {16'd0, vecs[i].pos});
            chk("vec_seg_remaining", {16'd0, seg_remaining}, {16'd0, vecs[i].rem});
            chk("vec_seg_done_count", done_cnt - d0, vecs[i].dn);
        end

        // seg_done exact timing on the last step of a 5-step segment.
        do_reset();
        set_dir(1'b1);
        do_arm(16'd5);
        do_step();
        chk("seg5_rem_after_first", {16'd0, seg_remaining}, 32'd4);
        for (int k = 0; k < 3; k++) do_step();
        step_in = ~step_in;
        cyc(LAT - 1);
        chk("seg5_done_early", {31'd0, seg_done}, 32'd0);
        cyc(1);
        chk("seg5_done_pulse", {31'd0, seg_done}, 32'd1);
        chk("seg5_rem_zero", {16'd0, seg_remaining}, 32'd0);
        chk("seg5_position", {16'd0, position}, 32'd5);
        cyc(1);
        chk("seg5_done_single", {31'd0, seg_done}, 32'd0);
        $display("seg5 pos=%h", position);

        // Reset mid-segment abandons it silently.
        do_arm(16'd5);
        do_step(); do_step();
        d0 = done_cnt;
        do_reset();
        chk("midrst_rem", {16'd0, seg_remaining}, 32'd0);
        chk("midrst_no_done", done_cnt - d0, 0);
        chk("midrst_position", {16'd0, position}, 32'd0);

        // Reload mid-segment, then reload coincident with an edge.
        set_dir(1'b1);
        do_arm(16'd10);
        for (int k = 0; k < 4; k++) do_step();
        d0 = done_cnt;
        do_arm(16'd3);
        chk("reload_no_done", done_cnt - d0, 0);
        chk("reload_rem", {16'd0, seg_remaining}, 32'd3);
        for (int k = 0; k < 3; k++) do_step();
        chk("reload_done", done_cnt - d0, 1);
        chk("reload_position", {16'd0, position}, 32'd7);
        step_in = ~step_in;
        cyc(2 + FE);
        deltaPos = 16'd9; newPosSignal = 1'b1;
        cyc(1);
        newPosSignal = 1'b0;
        cyc(2);
        chk("coinc_rem", {16'd0, seg_remaining}, 32'd9);
        chk("coinc_position", {16'd0, position}, 32'd8);
        $display("reload pos=%h rem=%h", position, seg_remaining);

`ifdef STEP_GLITCH_FILTER_EN
        p0 = position;
        step_in = ~step_in; cyc(2); step_in = ~step_in; cyc(12);
        chk("glitch_ignored", {16'd0, position}, {16'd0, p0});
`endif

        // Rate window: a step every 100 clocks, a tick every 1000.
        for (int c = 0; c < 3000; c++) begin
            clock_4ms = (c % 1000 == 999);
            if (c % 100 == 50) step_in = ~step_in;
            cyc(1);
            if (c % 1000 == 999 && c > 999) chk("rate_10", {24'd0, steps_per_tick}, 32'd10);
        end
        clock_4ms = 1'b0;
        $display("rate spt=%0d", steps_per_tick);

`ifndef STEP_GLITCH_FILTER_EN
        tick_pulse();
        for (int k = 0; k < 300; k++) begin
            step_in = ~step_in;
            cyc(1);
        end
        cyc(4);
        tick_pulse();
        chk("rate_saturate", {24'd0, steps_per_tick}, 32'd255);
`endif

        // Moving drops after IDLE_TICKS quiet ticks.
        step_in = ~step_in;
        cyc(LAT + 2);
        chk("moving_high", {31'd0, moving}, 32'd1);
        for (int t = 0; t < 7; t++) begin
            tick_pulse();
            cyc(2);
        end
        chk("moving_after_7", {31'd0, moving}, 32'd1);
        tick_pulse();
        chk("moving_after_8", {31'd0, moving}, 32'd0);
        chk("rate_quiet", {24'd0, steps_per_tick}, 32'd0);
        $display("moving=%0d", moving);

        // Direction-setup violation, clear, set-wins, and a clean step.
        chk("dir_err_clean", {31'd0, dir_err}, 32'd0);
        if (FE == 0) begin
            dir_in = ~dir_in; cyc(1); step_in = ~step_in;
        end else begin
            step_in = ~step_in; cyc(FE - 1); dir_in = ~dir_in;
        end
        cyc(LAT + 1);
        chk("dir_err_set", {31'd0, dir_err}, 32'd1);
        clr_err = 1'b1; cyc(1); clr_err = 1'b0; cyc(1);
        chk("dir_err_clr", {31'd0, dir_err}, 32'd0);
        if (FE == 0) begin
            dir_in = ~dir_in; cyc(1); step_in = ~step_in; cyc(2);
        end else begin
            step_in = ~step_in; cyc(FE - 1); dir_in = ~dir_in; cyc(3);
        end
        clr_err = 1'b1; cyc(1); clr_err = 1'b0; cyc(1);
        chk("dir_err_set_wins", {31'd0, dir_err}, 32'd1);
        clr_err = 1'b1; cyc(1); clr_err = 1'b0;
        dir_in = ~dir_in; cyc(6);
        do_step();
        chk("dir_err_ok_setup", {31'd0, dir_err}, 32'd0);
        $display("dir_err=%0d", dir_err);

        // Randomized arms and steps against the reference model.
        do_reset();
        m_pos = 16'd0; m_rem = 16'd0; m_done = 0;
        d0 = done_cnt;
        for (int i = 0; i < 40; i++) begin
            int op;
            op = $urandom_range(0, 3);
            if (op == 0) begin
                logic [15:0] dp;
                dp = 16'($urandom_range(0, 4));
                do_arm(dp);
                m_arm(dp);
            end else begin
                logic d;
                d = 1'($urandom_range(0, 1));
                set_dir(d);
                do_step();
                m_step(d);
            end
            chk("rand_position", {16'd0, position}, {16'd0, m_pos});
            chk("rand_seg_remaining", {16'd0, seg_remaining}, {16'd0, m_rem});
            chk("rand_seg_done_count", done_cnt - d0, m_done);
        end
        chk("rand_dir_err", {31'd0, dir_err}, 32'd0);
        $display("random pos=%h rem=%h done=%0d", position, seg_remaining, done_cnt - d0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
